// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Start/ready restoring divider (2N-bit / N-bit), one quotient bit
//            per clock. Optional div_zero flag when DIV_ZERO_FLAG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] input0,
  input  logic [N-1:0]   input1,
  output logic [2*N-1:0] output0,
  output logic [N-1:0]   output1,
  output logic           ready,
  output logic           busy
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic           div_zero
`endif
);

  localparam int CNT_W = $clog2(2*N+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N-1:0]     rem_q;
  logic [N-1:0]     rem_d;
  logic [N-1:0]     dvs_q;
  logic [2*N-1:0]   quo_q;
  logic [2*N-1:0]   quo_d;
  logic [2*N-1:0]   output0_q;
  logic [N-1:0]     output1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic [N:0]       shift_r;
  logic             fits;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero_q;
`endif

  // The partial remainder always stays below the divisor, so N bits hold it
  // between iterations; only the shifted trial value needs the extra bit.
  always_comb begin
    shift_r = {rem_q, quo_q[2*N-1]};
    fits    = (shift_r >= {1'b0, dvs_q});
    rem_d   = fits ? (shift_r[N-1:0] - dvs_q) : shift_r[N-1:0];
    quo_d   = {quo_q[2*N-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      output0_q <= '0;
      output1_q <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dvs_q  <= input1;
            cnt_q  <= CNT_W'(2*N);
            busy_q <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
            if (input1 == '0) begin
              rem_q   <= input0[N-1:0];
              quo_q   <= '1;
              state_q <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= input0;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            output0_q <= quo_d;
            output1_q <= rem_d;
            ready_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          // Arriving here with ready low only happens on the divide-by-zero path.
          if (ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            output0_q <= quo_q;
            output1_q <= rem_q;
            ready_q   <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign output0 = output0_q;
  assign output1 = output1_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero = div_zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider with a plain-arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  localparam int N   = 24;
  localparam int LAT = 2*N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [47:0]   input0 = '0;
  logic [23:0]   input1 = '0;
  logic [47:0]   output0;
  logic [23:0]   output1;
  logic          ready;
  logic          busy;
`ifdef DIV_ZERO_FLAG_EN
  logic          div_zero;
`endif

  seq_divider #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .input0  (input0),
    .input1  (input1),
    .output0 (output0),
    .output1 (output1),
    .ready   (ready),
    .busy    (busy)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] a;
    logic [23:0] b;
    logic [47:0] q;
    logic [23:0] r;
    logic        dz;
    int          edge_exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          edge_no = 0;
  logic        rs;
  logic [47:0] prev0 = '0;
  logic [23:0] prev1 = '0;
  logic [71:0] prod;

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Reference model: ordinary division, with the defined divide-by-zero result.
  task automatic push_exp(input logic [47:0] a, input logic [23:0] b, input int e0);
    exp_t x;
    x.a = a;
    x.b = b;
    if (b == 24'd0) begin
      x.q = {48{1'b1}};
      x.r = a[23:0];
      x.dz = 1'b1;
      x.edge_exp = e0 + 1;
    end else begin
      x.q = a / {24'd0, b};
      x.r = 24'(a % {24'd0, b});
      x.dz = 1'b0;
      x.edge_exp = e0 + LAT;
    end
    sb.push_back(x);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      rs = rst_n;
      #1;
      if (!rs) begin
        sb.delete();
        prev0 = '0;
        prev1 = '0;
        chk("rst_output0", 72'(output0), 72'd0);
        chk("rst_output1", 72'(output1), 72'd0);
        chk("rst_ready",   72'(ready),   72'd0);
        chk("rst_busy",    72'(busy),    72'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("rst_div_zero", 72'(div_zero), 72'd0);
`endif
      end else if (ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready: got ready=1 at edge %0d required no pending op", edge_no);
        end else begin
          e = sb.pop_front();
          chk("quotient",  72'(output0), 72'(e.q));
          chk("remainder", 72'(output1), 72'(e.r));
          chk("latency",   72'(edge_no), 72'(e.edge_exp));
          chk("busy_with_ready", 72'(busy), 72'd1);
`ifdef DIV_ZERO_FLAG_EN
          chk("div_zero", 72'(div_zero), 72'(e.dz));
`endif
          if (e.b != 24'd0) begin
            prod = 72'(output0) * 72'(e.b) + 72'(output1);
            chk("invariant", prod, 72'(e.a));
            chk("rem_lt_div", 72'(output1 < e.b), 72'd1);
          end
          prev0 = e.q;
          prev1 = e.r;
        end
      end else begin
        chk("hold_output0", 72'(output0), 72'(prev0));
        chk("hold_output1", 72'(output1), 72'(prev1));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 for %0d cycles required idle", t);
    end
  endtask

  task automatic issue(input logic [47:0] a, input logic [23:0] b);
    wait_idle();
    input0 = a;
    input1 = b;
    start  = 1'b1;
    push_exp(a, b, edge_no + 1);
    @(negedge clk);
    start  = 1'b0;
    input0 = 48'({$urandom(), $urandom()});
    input1 = 24'($urandom());
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] a;
    logic [23:0] b;
    int e0;
    int t;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan.
    issue(48'h000000000064, 24'h000007);
    issue(48'hFFFFFFFFFFFF, 24'h000001);
    issue(48'hFFFFFFFFFFFF, 24'hFFFFFF);
    issue(48'h123456789ABC, 24'h000000);
    issue(48'h000000000005, 24'h000009);
    wait_drain();

    // Reset in the middle of an operation.
    wait_idle();
    input0 = 48'd100;
    input1 = 24'd7;
    start  = 1'b1;
    e0 = edge_no + 1;
    push_exp(48'd100, 24'd7, e0);
    @(negedge clk);
    start = 1'b0;
    while (edge_no < e0 + 19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(48'd100, 24'd7);
    wait_drain();

    // Start held high while busy with changing inputs, then re-accepted back-to-back.
    wait_idle();
    a = 48'({$urandom(), $urandom()});
    b = 24'($urandom_range(1, 24'hFFFFFF));
    input0 = a;
    input1 = b;
    start  = 1'b1;
    push_exp(a, b, edge_no + 1);
    t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      input0 = 48'({$urandom(), $urandom()});
      input1 = 24'($urandom());
      @(negedge clk);
      t++;
    end
    a = 48'({$urandom(), $urandom()});
    b = 24'($urandom_range(1, 24'hFFFFFF));
    input0 = a;
    input1 = b;
    push_exp(a, b, edge_no + 2);
    repeat (2) @(negedge clk);
    start = 1'b0;
    input0 = 48'({$urandom(), $urandom()});
    input1 = 24'($urandom());
    wait_drain();

    // Random operands, including small dividends and zero divisors.
    for (int i = 0; i < 30; i++) begin
      a = (i % 3 == 0) ? 48'($urandom_range(0, 5000)) : 48'({$urandom(), $urandom()});
      b = (i % 10 == 7) ? 24'd0 : 24'($urandom_range(1, 24'hFFFFFF));
      issue(a, b);
    end
    wait_drain();

    // Round-robin feed: operands step by one after every result.
    a = 48'({$urandom(), $urandom()});
    b = 24'($urandom_range(1, 24'hFFF000));
    for (int i = 0; i < 1000; i++) begin
      issue(a, b);
      a = a + 48'd1;
      b = b + 24'd1;
    end
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse operation of the team's start/ready sequential 24x24 multiplier.
- Divides a 2N-bit dividend by an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock.
- Uses the same start/ready handshake as the multiplier, so the two blocks can be chained in round-trip checks (multiply, then divide back).

Parameters:
N, 24, divisor/remainder width; dividend and quotient width is 2N.

Ports:
clk      input   1     system clock, all state updates on rising edge
rst_n    input   1     synchronous active-low reset
start    input   1     request; sampled only in IDLE
input0   input   2N    dividend, captured on accepted start
input1   input   N     divisor, captured on accepted start
output0  output  2N    quotient
output1  output  N     remainder
ready    output  1     one-cycle pulse: results valid
busy     output  1     high in BUSY and DONE

Behaviour:
- Reset: all of these are 0 in the cycle after any rising edge with rst_n=0, regardless of state:
  - output0, output1, ready, busy.
  - Internal registers and iteration counter.
  - State returns to IDLE.
  - Reset overrides start.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at an edge (edge E0) captures input0 and input1.
  - Loads partial remainder R=0 (N+1 bits), quotient shift register Q=input0, counter=2N.
  - If input1!=0, go to BUSY.
  - If input1==0, go to DONE directly, with quotient=all ones and remainder=input0[N-1:0].
- BUSY, each edge:
  - Shift {R,Q} left by 1.
  - Trial T = R - {1'b0,divisor}.
  - If T is non-negative, set R=T and Q[0]=1; else Q[0]=0.
  - Decrement counter. After the 2N-th iteration edge (E0+2N), go to DONE.
- DONE:
  - Update output0 and output1 from Q and R[N-1:0] on the same edge as entry.
  - ready=1 and busy=1 for exactly one cycle, then go to IDLE, where ready=0 and busy=0.
- Latency:
  - ready is high during the cycle after edge E0+2N, i.e. sampled high at edge E0+2N+1 (49 for N=24).
  - Divide-by-zero: ready is sampled high at edge E0+2.
- output0 and output1 hold their values until the next DONE entry or reset. They never change in IDLE or BUSY.
- start while BUSY or DONE is ignored; it is not queued.
- start held high continuously gives back-to-back operations: re-accepted at the first IDLE edge.
- input0 and input1 may change freely after the accept edge.
- Arithmetic invariant for divisor!=0: output0*input1 + output1 == input0, and output1 < input1.
- No overflow case exists, since the quotient width equals the dividend width.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output port div_zero (1 bit).
  - div_zero is set together with ready when the captured divisor was 0.
  - It holds its value alongside output0.
  - It is cleared on the next accepted start and on reset.
- Undefined: no port. Divide-by-zero still returns all-ones quotient and remainder = dividend[N-1:0].

Test Plan:
1. Small divide: input0=0x000000000064, input1=0x000007, start pulse -> ready sampled at E0+49; output0=0x00000000000E, output1=0x000002.
2. Extremes:
   - 0xFFFFFFFFFFFF/0x000001 -> output0=0xFFFFFFFFFFFF, output1=0.
   - 0xFFFFFFFFFFFF/0xFFFFFF -> output0=0x000001000001, output1=0.
3. Divide by zero: input0=0x123456789ABC, input1=0 -> ready sampled at E0+2; output0=0xFFFFFFFFFFFF, output1=0x789ABC; div_zero=1 when DIV_ZERO_FLAG_EN is defined.
4. Reset mid-operation: rst_n=0 for one edge at E0+20 -> the following cycle has busy=0, ready=0, outputs 0. A new start of 100/7 then completes normally with 14 r 2.
5. Protocol:
   - start held high in BUSY with changed inputs -> the operation in flight is unaffected, exactly one ready per accepted start.
   - Feed start<=ready with input0 and input1 each incremented after every ready, for 1000 operations -> the self-check output0*input1+output1==input0 and output1<input1 holds every time.
